uart_pkt_engine: RTL and testbench
==================================

# uart_pkt_engine

Parametrised packet layer between the byte-level `receiver`/`transmitter` UART modules and command-decode logic. It frames incoming bytes into packets, closing on idle timeout, terminator character or maximum length, and holds each packet for random-access reading until acknowledged. It streams length-counted response packets, which may contain 0x00, to the transmitter with a byte handshake and a programmable inter-byte gap.

## Interface
Parameters:
- `MAX_LEN`, 16: RX and TX buffer depth in bytes (≥2).
- `IDLE_CYC`, 5000000: idle clocks after the last byte that close an RX packet.
- `TERM_EN`, 1: 1 = `TERM_CHAR` closes a packet.
- `TERM_CHAR`, 8'h0A: terminator byte; it is never stored.
- `TX_GAP`, 5: minimum clocks between `tx_wr_en` pulses (≥2).

Ports (LW = clog2(MAX_LEN+1), AW = clog2(MAX_LEN)):
- `CLK` in 1: system clock (50 MHz).
- `RST_N` in 1: asynchronous, active-low reset.
- `rx_data` in 8: byte from `receiver`.
- `rx_rdy` in 1: receiver ready level; a rising edge means a new byte.
- `rx_pkt_valid` out 1: a packet is held.
- `rx_pkt_len` out LW: held length.
- `rx_pkt_ovf` out 1: sticky flag; bytes were dropped.
- `rx_rd_addr` in AW: read address.
- `rx_rd_data` out 8: combinational read of the RX buffer.
- `rx_pkt_ack` in 1: release the held packet.
- `tx_ld_en` in 1: TX buffer write enable.
- `tx_ld_addr` in AW: TX buffer write address.
- `tx_ld_data` in 8: TX buffer write data.
- `tx_pkt_start` in 1: one-cycle pulse; send the packet.
- `tx_pkt_len` in LW: length to send, sampled on start.
- `tx_pkt_busy` out 1: send in progress.
- `tx_pkt_done` out 1: one-cycle pulse when the send completes.
- `tx_din` out 8: byte to `transmitter`.
- `tx_wr_en` out 1: one-cycle write strobe.
- `tx_busy` in 1: transmitter busy.

## Operation
- RX states:
  - `R_FILL` (after reset): detect a rising edge of `rx_rdy` using a registered copy of the previous value.
    - On an edge with `TERM_EN` set and byte == `TERM_CHAR`: if len > 0, go to `R_HOLD`. Empty packets are ignored.
    - On any other edge: write the byte at address len, increment len, restart the idle counter. If len reaches `MAX_LEN`, go to `R_HOLD`.
    - The idle counter runs only when len > 0. Reaching `IDLE_CYC` goes to `R_HOLD`.
  - `R_HOLD`: `rx_pkt_valid`=1; `rx_pkt_len` and the buffer are frozen.
    - A byte edge drops the byte and sets `rx_pkt_ovf`.
    - `rx_pkt_ack` clears valid, ovf, len and the idle counter, and returns to `R_FILL`.
    - A byte edge in the same cycle as ack is dropped, and ovf still clears.
- TX states:
  - `T_IDLE`: `tx_ld_en` writes the buffer.
    - Start with len = 0: pulse `tx_pkt_done` next cycle, send nothing.
    - Start with len > 0: latch len, clear the index, preload the gap counter to `TX_GAP`, go to `T_SEND`.
  - `T_SEND`: `tx_pkt_busy`=1; the gap counter increments, saturating.
    - When `tx_busy`=0 and gap ≥ `TX_GAP`: drive `tx_din` = buf[idx], pulse `tx_wr_en`, increment idx, zero the gap.
    - After the last byte, go to `T_DRAIN`.
  - `T_DRAIN`: wait for gap ≥ `TX_GAP` and `tx_busy`=0, then pulse `tx_pkt_done` and return to `T_IDLE`.
  - `tx_pkt_start` and `tx_ld_en` are ignored unless in `T_IDLE`.
  - A 0x00 byte is sent like any other byte.
- RX and TX are fully independent.

## Timing
- Reset values: all outputs 0. Both state machines go idle (`R_FILL`/`T_IDLE`), all counters and lengths return to 0, and the ovf flag clears. Buffer contents are undefined. Reset mid-packet aborts without a `tx_pkt_done` pulse.
- Byte capture happens at the first edge where `rx_rdy`=1 and the previous sample was 0.
- `rx_pkt_valid` rises one clock after the closing byte's capture edge, or exactly `IDLE_CYC` clocks after the last capture.
- RX buffer writes take effect next cycle; `rx_rd_data` has zero latency from `rx_rd_addr`.
- The first `tx_wr_en` occurs one cycle after start if `tx_busy`=0. Subsequent strobes are ≥`TX_GAP` clocks apart.
- Counter widths: the idle counter is clog2(`IDLE_CYC`+1) bits; the gap counter is clog2(`TX_GAP`+1) bits. Neither counter wraps.

## Structure
- Package `uart_pkt_pkg`: RX/TX state encodings, a `clog2` function, and ASCII constants (LF, CR, space).
- One sub-module, `uart_pkt_buf`: an `MAX_LEN`×8 register array with synchronous write and asynchronous read. It is instantiated twice, once for RX and once for TX.

## Test plan
- Send "LED 1 ON" then LF at 115200 baud → valid with len=8, buffer reads match, the LF is not stored, ovf=0.
- Send "TIM STOP" with no terminator → valid exactly `IDLE_CYC` clocks after the 'P' capture, len=8.
- Send 18 bytes with `MAX_LEN`=16 → valid after byte 16, len=16, ovf=1. After ack, ovf=0 and the next packet starts fresh.
- Load 4A 00 0A 42, start with len=4 and a `tx_busy` model (1 clock after wr_en, 10 clocks busy) → exactly 4 strobes with `tx_din` 4A,00,0A,42, spacing ≥`TX_GAP`, then one `tx_pkt_done` pulse.
- Start with len=0 → done pulse next cycle and no strobe. A second start during busy is ignored, with byte count unchanged.
- Assert `RST_N` low mid-RX and mid-TX → all outputs 0 immediately with no done pulse. A clean packet after release frames correctly.

Source files
------------

// File: rtl/uart_pkt_pkg.sv
// Shared types, width helper and ASCII constants for the UART packet engine.
package uart_pkt_pkg;

  typedef enum logic {
    R_FILL,
    R_HOLD
  } rxState_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_SEND,
    T_DRAIN
  } txState_t;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_SP = 8'h20;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    longint unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_pkt_engine_if.sv
// Packet-layer signal bundle: RX byte/packet side and TX packet/byte side.
interface uart_pkt_engine_if
  import uart_pkt_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16
) ();
  localparam int unsigned LW = clog2(MAX_LEN + 1);
  localparam int unsigned AW = clog2(MAX_LEN);

  logic [7:0]    rx_data;
  logic          rx_rdy;
  logic          rx_pkt_valid;
  logic [LW-1:0] rx_pkt_len;
  logic          rx_pkt_ovf;
  logic [AW-1:0] rx_rd_addr;
  logic [7:0]    rx_rd_data;
  logic          rx_pkt_ack;
  logic          tx_ld_en;
  logic [AW-1:0] tx_ld_addr;
  logic [7:0]    tx_ld_data;
  logic          tx_pkt_start;
  logic [LW-1:0] tx_pkt_len;
  logic          tx_pkt_busy;
  logic          tx_pkt_done;
  logic [7:0]    tx_din;
  logic          tx_wr_en;
  logic          tx_busy;

  modport master (
    output rx_data, rx_rdy, rx_rd_addr, rx_pkt_ack,
    output tx_ld_en, tx_ld_addr, tx_ld_data, tx_pkt_start, tx_pkt_len, tx_busy,
    input  rx_pkt_valid, rx_pkt_len, rx_pkt_ovf, rx_rd_data,
    input  tx_pkt_busy, tx_pkt_done, tx_din, tx_wr_en
  );

  modport slave (
    input  rx_data, rx_rdy, rx_rd_addr, rx_pkt_ack,
    input  tx_ld_en, tx_ld_addr, tx_ld_data, tx_pkt_start, tx_pkt_len, tx_busy,
    output rx_pkt_valid, rx_pkt_len, rx_pkt_ovf, rx_rd_data,
    output tx_pkt_busy, tx_pkt_done, tx_din, tx_wr_en
  );

endinterface

// File: rtl/uart_pkt_buf.sv
// Byte register array: synchronous write, asynchronous read, no reset.
module uart_pkt_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          CLK,
  input  logic          wrEn,
  input  logic [AW-1:0] wrAddr,
  input  logic [7:0]    wrData,
  input  logic [AW-1:0] rdAddr,
  output logic [7:0]    rdData
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/uart_pkt_engine.sv
// Packet framing of received UART bytes and paced streaming of response packets.
module uart_pkt_engine
  import uart_pkt_pkg::*;
#(
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned IDLE_CYC  = 5000000,
  parameter bit          TERM_EN   = 1'b1,
  parameter logic [7:0]  TERM_CHAR = 8'h0A,
  parameter int unsigned TX_GAP    = 5
) (
  input logic              CLK,
  input logic              RST_N,
  uart_pkt_engine_if.slave bus
);

  localparam int unsigned LW = clog2(MAX_LEN + 1);
  localparam int unsigned AW = clog2(MAX_LEN);
  localparam int unsigned IW = clog2(IDLE_CYC + 1);
  localparam int unsigned GW = clog2(TX_GAP + 1);

  localparam logic [LW-1:0] MAX_L  = LW'(MAX_LEN);
  localparam logic [IW-1:0] IDLE_L = IW'(IDLE_CYC);
  localparam logic [GW-1:0] GAP_L  = GW'(TX_GAP);

  rxState_t      rxState;
  logic          rxRdyPrev;
  logic [LW-1:0] rxLen;
  logic [IW-1:0] idleCnt;
  logic          rxValid;
  logic          rxOvf;
  logic          rxEdge;
  logic          rxIsTerm;
  logic          rxWrEn;

  assign rxEdge   = bus.rx_rdy & ~rxRdyPrev;
  assign rxIsTerm = TERM_EN && (bus.rx_data == TERM_CHAR);
  assign rxWrEn   = (rxState == R_FILL) && rxEdge && !rxIsTerm;

  uart_pkt_buf #(.DEPTH(MAX_LEN), .AW(AW)) rxBuf (
    .CLK    (CLK),
    .wrEn   (rxWrEn),
    .wrAddr (rxLen[AW-1:0]),
    .wrData (bus.rx_data),
    .rdAddr (bus.rx_rd_addr),
    .rdData (bus.rx_rd_data)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rxState   <= R_FILL;
      rxRdyPrev <= 1'b0;
      rxLen     <= '0;
      idleCnt   <= '0;
      rxValid   <= 1'b0;
      rxOvf     <= 1'b0;
    end else begin
      rxRdyPrev <= bus.rx_rdy;
      case (rxState)
        R_FILL: begin
          if (rxEdge) begin
            if (rxIsTerm) begin
              if (rxLen != '0) begin
                rxState <= R_HOLD;
                rxValid <= 1'b1;
              end
            end else begin
              rxLen   <= rxLen + LW'(1);
              idleCnt <= '0;
              if (rxLen == MAX_L - LW'(1)) begin
                rxState <= R_HOLD;
                rxValid <= 1'b1;
              end
            end
          end else if (rxLen != '0) begin
            idleCnt <= idleCnt + IW'(1);
            if (idleCnt + IW'(1) == IDLE_L) begin
              rxState <= R_HOLD;
              rxValid <= 1'b1;
            end
          end
        end
        R_HOLD: begin
          // Ack wins over a coincident byte edge: the byte is lost and ovf still clears.
          if (bus.rx_pkt_ack) begin
            rxState <= R_FILL;
            rxValid <= 1'b0;
            rxOvf   <= 1'b0;
            rxLen   <= '0;
            idleCnt <= '0;
          end else if (rxEdge) begin
            rxOvf <= 1'b1;
          end
        end
        default: rxState <= R_FILL;
      endcase
    end
  end

  assign bus.rx_pkt_valid = rxValid;
  assign bus.rx_pkt_len   = rxLen;
  assign bus.rx_pkt_ovf   = rxOvf;

  txState_t      txState;
  logic [LW-1:0] txLen;
  logic [LW-1:0] txIdx;
  logic [GW-1:0] gapCnt;
  logic          txBusyR;
  logic          txDone;
  logic [7:0]    txDin;
  logic          txWrEn;
  logic [7:0]    txRdData;
  logic          txLdEn;

  assign txLdEn = bus.tx_ld_en && (txState == T_IDLE);

  uart_pkt_buf #(.DEPTH(MAX_LEN), .AW(AW)) txBuf (
    .CLK    (CLK),
    .wrEn   (txLdEn),
    .wrAddr (bus.tx_ld_addr),
    .wrData (bus.tx_ld_data),
    .rdAddr (txIdx[AW-1:0]),
    .rdData (txRdData)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      txState <= T_IDLE;
      txLen   <= '0;
      txIdx   <= '0;
      gapCnt  <= '0;
      txBusyR <= 1'b0;
      txDone  <= 1'b0;
      txDin   <= '0;
      txWrEn  <= 1'b0;
    end else begin
      txWrEn <= 1'b0;
      txDone <= 1'b0;
      case (txState)
        T_IDLE: begin
          if (bus.tx_pkt_start) begin
            if (bus.tx_pkt_len == '0) begin
              txDone <= 1'b1;
            end else begin
              txLen   <= bus.tx_pkt_len;
              txIdx   <= '0;
              gapCnt  <= GAP_L;
              txBusyR <= 1'b1;
              txState <= T_SEND;
            end
          end
        end
        T_SEND: begin
          if (!bus.tx_busy && gapCnt >= GAP_L) begin
            txDin  <= txRdData;
            txWrEn <= 1'b1;
            txIdx  <= txIdx + LW'(1);
            gapCnt <= '0;
            if (txIdx == txLen - LW'(1)) txState <= T_DRAIN;
          end else if (gapCnt != GAP_L) begin
            gapCnt <= gapCnt + GW'(1);
          end
        end
        T_DRAIN: begin
          if (!bus.tx_busy && gapCnt >= GAP_L) begin
            txDone  <= 1'b1;
            txBusyR <= 1'b0;
            txState <= T_IDLE;
          end else if (gapCnt != GAP_L) begin
            gapCnt <= gapCnt + GW'(1);
          end
        end
        default: txState <= T_IDLE;
      endcase
    end
  end

  assign bus.tx_pkt_busy = txBusyR;
  assign bus.tx_pkt_done = txDone;
  assign bus.tx_din      = txDin;
  assign bus.tx_wr_en    = txWrEn;

endmodule

// File: tb/tb_uart_pkt_engine.sv
// Directed bench for uart_pkt_engine: RX framing, TX pacing and reset behaviour.
module tb_uart_pkt_engine;
  import uart_pkt_pkg::*;

  localparam int unsigned MAX_LEN  = 16;
  localparam int unsigned IDLE_CYC = 60;
  localparam int unsigned TX_GAP   = 5;

  logic CLK = 1'b0;
  logic RST_N;
  always #10 CLK = ~CLK;

  uart_pkt_engine_if #(.MAX_LEN(MAX_LEN)) bus ();

  uart_pkt_engine #(
    .MAX_LEN   (MAX_LEN),
    .IDLE_CYC  (IDLE_CYC),
    .TERM_EN   (1'b1),
    .TERM_CHAR (ASCII_LF),
    .TX_GAP    (TX_GAP)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int assertCount = 0;
  int failCount   = 0;
  int unsigned cyc = 0;

  logic [7:0]  strobeData[$];
  int unsigned strobeCyc[$];
  int          doneCount = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge CLK);
      if (bus.tx_wr_en === 1'b1) begin
        strobeData.push_back(bus.tx_din);
        strobeCyc.push_back(cyc);
      end
      if (bus.tx_pkt_done === 1'b1) doneCount++;
    end
  end

  // Transmitter stand-in: goes busy one clock after a strobe, for 10 clocks.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge CLK);
      if (bus.tx_wr_en === 1'b1) begin
        @(negedge CLK);
        bus.tx_busy = 1'b1;
        repeat (10) @(negedge CLK);
        bus.tx_busy = 1'b0;
      end
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    @(negedge CLK);
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    @(negedge CLK);
    bus.rx_rdy  = 1'b0;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic ackPkt();
    @(negedge CLK);
    bus.rx_pkt_ack = 1'b1;
    @(negedge CLK);
    bus.rx_pkt_ack = 1'b0;
  endtask

  task automatic loadByte(input logic [3:0] a, input logic [7:0] d);
    @(negedge CLK);
    bus.tx_ld_en   = 1'b1;
    bus.tx_ld_addr = a;
    bus.tx_ld_data = d;
    @(negedge CLK);
    bus.tx_ld_en   = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [3:0] a, input logic [7:0] exp);
    bus.rx_rd_addr = a;
    #1;
    checkVal(tag, {24'd0, bus.rx_rd_data}, {24'd0, exp});
  endtask

  task automatic waitDone(input string tag, input int target);
    int n;
    n = 0;
    while (doneCount < target && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    repeat (2) @(negedge CLK);
    checkVal(tag, doneCount, target);
  endtask

  logic [7:0] msgLed [8] = '{8'h4C, 8'h45, 8'h44, 8'h20, 8'h31, 8'h20, 8'h4F, 8'h4E};
  logic [7:0] msgTim [8] = '{8'h54, 8'h49, 8'h4D, 8'h20, 8'h53, 8'h54, 8'h4F, 8'h50};
  logic [7:0] txPat  [4] = '{8'h4A, 8'h00, 8'h0A, 8'h42};

  initial begin
    int base;
    int doneBase;
    int startCyc;
    int n;
    int strobesAtRst;
    int doneAtRst;

    RST_N            = 1'b0;
    bus.rx_data      = '0;
    bus.rx_rdy       = 1'b0;
    bus.rx_rd_addr   = '0;
    bus.rx_pkt_ack   = 1'b0;
    bus.tx_ld_en     = 1'b0;
    bus.tx_ld_addr   = '0;
    bus.tx_ld_data   = '0;
    bus.tx_pkt_start = 1'b0;
    bus.tx_pkt_len   = '0;
    repeat (3) @(negedge CLK);
    checkVal("rst_valid", bus.rx_pkt_valid, 0);
    checkVal("rst_len", bus.rx_pkt_len, 0);
    checkVal("rst_ovf", bus.rx_pkt_ovf, 0);
    checkVal("rst_txbusy", bus.tx_pkt_busy, 0);
    checkVal("rst_done", bus.tx_pkt_done, 0);
    checkVal("rst_wren", bus.tx_wr_en, 0);
    checkVal("rst_din", bus.tx_din, 0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // "LED 1 ON" + LF
    for (int i = 0; i < 8; i++) begin
      sendByte(msgLed[i], 8);
      checkVal("led_not_early", bus.rx_pkt_valid, 0);
    end
    sendByte(ASCII_LF, 2);
    checkVal("led_valid", bus.rx_pkt_valid, 1);
    checkVal("led_len", bus.rx_pkt_len, 8);
    checkVal("led_ovf", bus.rx_pkt_ovf, 0);
    for (int i = 0; i < 8; i++) readCheck("led_data", 4'(i), msgLed[i]);
    ackPkt();
    checkVal("led_ack_valid", bus.rx_pkt_valid, 0);
    checkVal("led_ack_len", bus.rx_pkt_len, 0);

    // "TIM STOP" closed by idle timeout
    for (int i = 0; i < 7; i++) sendByte(msgTim[i], 10);
    sendByte(msgTim[7], 0);
    checkVal("tim_valid_capture", bus.rx_pkt_valid, 0);
    n = 0;
    while (bus.rx_pkt_valid !== 1'b1 && n < 2 * IDLE_CYC) begin
      @(negedge CLK);
      n++;
    end
    checkVal("tim_idle_delay", n, IDLE_CYC);
    checkVal("tim_len", bus.rx_pkt_len, 8);
    readCheck("tim_data7", 4'd7, 8'h50);
    readCheck("tim_data0", 4'd0, 8'h54);
    ackPkt();

    // 18 bytes into a 16-byte buffer
    for (int i = 0; i < 16; i++) sendByte(8'h41 + 8'(i), 3);
    checkVal("full_valid", bus.rx_pkt_valid, 1);
    checkVal("full_ovf_before", bus.rx_pkt_ovf, 0);
    sendByte(8'h51, 3);
    sendByte(8'h52, 3);
    checkVal("full_len", bus.rx_pkt_len, 16);
    checkVal("full_ovf", bus.rx_pkt_ovf, 1);
    readCheck("full_data15", 4'd15, 8'h50);
    ackPkt();
    checkVal("full_ack_ovf", bus.rx_pkt_ovf, 0);
    checkVal("full_ack_valid", bus.rx_pkt_valid, 0);
    sendByte(8'h4F, 3);
    sendByte(8'h4B, 3);
    sendByte(ASCII_LF, 2);
    checkVal("fresh_len", bus.rx_pkt_len, 2);
    readCheck("fresh_data0", 4'd0, 8'h4F);
    readCheck("fresh_data1", 4'd1, 8'h4B);

    // Byte edge coincident with ack is dropped; lone LF forms no packet
    @(negedge CLK);
    bus.rx_pkt_ack = 1'b1;
    bus.rx_data    = 8'h51;
    bus.rx_rdy     = 1'b1;
    @(negedge CLK);
    bus.rx_pkt_ack = 1'b0;
    bus.rx_rdy     = 1'b0;
    checkVal("ackedge_valid", bus.rx_pkt_valid, 0);
    checkVal("ackedge_len", bus.rx_pkt_len, 0);
    checkVal("ackedge_ovf", bus.rx_pkt_ovf, 0);
    sendByte(ASCII_LF, 3);
    checkVal("emptyterm_valid", bus.rx_pkt_valid, 0);
    checkVal("emptyterm_len", bus.rx_pkt_len, 0);

    // TX: 4A 00 0A 42
    for (int i = 0; i < 4; i++) loadByte(4'(i), txPat[i]);
    base     = strobeData.size();
    doneBase = doneCount;
    @(negedge CLK);
    bus.tx_pkt_start = 1'b1;
    bus.tx_pkt_len   = 5'd4;
    @(negedge CLK);
    bus.tx_pkt_start = 1'b0;
    startCyc = cyc;
    checkVal("tx_busy_flag", bus.tx_pkt_busy, 1);
    waitDone("tx_done_count", doneBase + 1);
    checkVal("tx_strobes", strobeData.size() - base, 4);
    checkVal("tx_first_latency", strobeCyc[base] - startCyc, 1);
    for (int i = 0; i < 4; i++) checkVal("tx_data", strobeData[base + i], txPat[i]);
    for (int i = 1; i < 4; i++)
      checkVal("tx_spacing", (strobeCyc[base + i] - strobeCyc[base + i - 1]) >= TX_GAP, 1);
    checkVal("tx_idle_busy", bus.tx_pkt_busy, 0);

    // Zero-length start
    base = strobeData.size();
    @(negedge CLK);
    bus.tx_pkt_start = 1'b1;
    bus.tx_pkt_len   = 5'd0;
    @(negedge CLK);
    bus.tx_pkt_start = 1'b0;
    checkVal("zero_done_pulse", bus.tx_pkt_done, 1);
    @(negedge CLK);
    checkVal("zero_done_once", bus.tx_pkt_done, 0);
    repeat (10) @(negedge CLK);
    checkVal("zero_no_strobe", strobeData.size() - base, 0);

    // Start while busy is ignored
    loadByte(4'd0, 8'h11);
    loadByte(4'd1, 8'h22);
    loadByte(4'd2, 8'h33);
    base     = strobeData.size();
    doneBase = doneCount;
    @(negedge CLK);
    bus.tx_pkt_start = 1'b1;
    bus.tx_pkt_len   = 5'd3;
    @(negedge CLK);
    bus.tx_pkt_start = 1'b0;
    repeat (4) @(negedge CLK);
    bus.tx_pkt_start = 1'b1;
    bus.tx_pkt_len   = 5'd1;
    bus.tx_ld_en     = 1'b1;
    bus.tx_ld_addr   = 4'd2;
    bus.tx_ld_data   = 8'hEE;
    @(negedge CLK);
    bus.tx_pkt_start = 1'b0;
    bus.tx_ld_en     = 1'b0;
    waitDone("busy_done_count", doneBase + 1);
    checkVal("busy_strobes", strobeData.size() - base, 3);
    checkVal("busy_last_byte", strobeData[strobeData.size() - 1], 8'h33);

    // Reset mid-RX and mid-TX
    sendByte(8'h41, 3);
    sendByte(8'h42, 3);
    loadByte(4'd0, 8'h4A);
    base = strobeData.size();
    @(negedge CLK);
    bus.tx_pkt_start = 1'b1;
    bus.tx_pkt_len   = 5'd4;
    @(negedge CLK);
    bus.tx_pkt_start = 1'b0;
    n = 0;
    while (strobeData.size() == base && n < 100) begin
      @(negedge CLK);
      n++;
    end
    checkVal("rstmid_tx_started", strobeData.size() - base, 1);
    checkVal("rstmid_rx_len", bus.rx_pkt_len, 2);
    @(negedge CLK);
    strobesAtRst = strobeData.size();
    doneAtRst    = doneCount;
    RST_N = 1'b0;
    #1;
    checkVal("rstmid_valid", bus.rx_pkt_valid, 0);
    checkVal("rstmid_len", bus.rx_pkt_len, 0);
    checkVal("rstmid_ovf", bus.rx_pkt_ovf, 0);
    checkVal("rstmid_txbusy", bus.tx_pkt_busy, 0);
    checkVal("rstmid_wren", bus.tx_wr_en, 0);
    checkVal("rstmid_din", bus.tx_din, 0);
    checkVal("rstmid_done", bus.tx_pkt_done, 0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (40) @(negedge CLK);
    checkVal("rstmid_no_done", doneCount, doneAtRst);
    checkVal("rstmid_no_strobe", strobeData.size(), strobesAtRst);
    checkVal("rstmid_rx_idle", bus.rx_pkt_valid, 0);
    sendByte(8'h4F, 3);
    sendByte(8'h4B, 3);
    sendByte(ASCII_LF, 2);
    checkVal("post_rst_valid", bus.rx_pkt_valid, 1);
    checkVal("post_rst_len", bus.rx_pkt_len, 2);
    readCheck("post_rst_data0", 4'd0, 8'h4F);
    ackPkt();

    loadByte(4'd0, 8'h55);
    base     = strobeData.size();
    doneBase = doneCount;
    @(negedge CLK);
    bus.tx_pkt_start = 1'b1;
    bus.tx_pkt_len   = 5'd1;
    @(negedge CLK);
    bus.tx_pkt_start = 1'b0;
    waitDone("post_rst_tx_done", doneBase + 1);
    checkVal("post_rst_tx_strobes", strobeData.size() - base, 1);
    checkVal("post_rst_tx_data", strobeData[strobeData.size() - 1], 8'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
